oam_scanner: RTL
================

// Module: oam_scanner
// PURPOSE
//  Mode-2 OAM scan: on start, walks all 40 OAM entries (2 T-cycles each), selects up to 10
//  sprites overlapping the current line, and builds the 10-slot sprite buffer that the sprite
//  fetcher reads in mode 3. Slot format is {X[17:10], sprite_num[9:4], row[3:0]}; X==0 means
//  the slot is ignored downstream. Sits between the LCDC/STAT timing control and the OAM BRAM.
// PARAMETERS
//  NUM_OBJS   40  OAM entries scanned (indices 0..NUM_OBJS-1)
//  MAX_SLOTS  10  sprite buffer depth / per-line sprite limit
//  OAM_BASE   16'hFE00  OAM base address
// PORTS
//  clk_in               in   1     system clock; all state on posedge
//  rst_in               in   1     asynchronous, active-low reset
//  tclk_in              in   1     T-cycle enable, one clk_in cycle wide; state advances only when high
//  start_in             in   1     begin scan (sampled when tclk_in high)
//  ly_in                in   8     current line LY
//  tall_sprite_mode_in  in   1     LCDC.2: 1 = 8x16 objects, 0 = 8x8
//  oam_addr_out         out  16    OAM byte address requested
//  oam_req_out          out  1     request strobe (= tclk_in && state in READ_Y/READ_X)
//  oam_data_in          in   8     OAM data for request of previous T-cycle
//  oam_valid_in         in   1     oam_data_in valid; invalid data is read as 8'hFF
//  sprite_buffer_out    out  18x10 sprite slots [9:0]
//  sprite_count_out     out  4     sprites captured this line (0..10)
//  busy_out             out  1     scan in progress
//  done_out             out  1     one clk_in cycle pulse when buffer final
// BEHAVIOUR
//  Reset (rst_in low, async): state IDLE; all slots 18'h0; count 0; busy/done/req 0; addr 16'h0.
//  States: IDLE, READ_Y, READ_X, DRAIN. Transitions only on clk_in edges with tclk_in high.
//  IDLE: start_in -> latch ly_in, tall_sprite_mode_in; clear all slots and count; idx=0;
//        pend=0; busy=1; -> READ_Y. start_in outside IDLE is ignored.
//  READ_Y: addr = OAM_BASE + 4*idx. If pend: commit(idx-1, y_hold, X=data). -> READ_X.
//  READ_X: y_hold <= data; addr = OAM_BASE + 4*idx + 1; pend <= 1;
//        idx==NUM_OBJS-1 -> DRAIN, else idx++ -> READ_Y.
//  DRAIN: commit(NUM_OBJS-1, y_hold, X=data); busy <= 0; done pulse; -> IDLE.
//  Data returned on tclk k belongs to the request issued on tclk k-1 (1-T-cycle latency).
//  data = oam_valid_in ? oam_data_in : 8'hFF.
//  commit(n, Y, X): h = tall ? 16 : 8; d = {1'b0,ly}+9'd16 - {1'b0,Y} (9-bit).
//    hit iff ({1'b0,ly}+16 >= {1'b0,Y}) && d < h. On hit and count<MAX_SLOTS:
//    slot[count] <= {X, n[5:0], d[3:0]}; count++. Hits with count==MAX_SLOTS dropped.
//    X==0 hits still occupy a slot and increment count (hardware 10-limit semantics).
//  Slots filled in ascending OAM order; unfilled slots stay 18'h0.
//  Latency: start tclk t0 -> done_out high for one clk_in cycle after the tclk at t0+81
//    (80 scan T-cycles + DRAIN). oam_req_out high on exactly 80 tclks per scan.
//  Outputs: buffer/count registered, valid to readers when busy_out==0.
//  Reset mid-scan: immediate abort to reset values; no done pulse.
//  tclk_in low: all state holds; oam_req_out low.
// TESTING
//  1) All Y=0, ly=0, start -> done at t0+81, count=0, all slots 0, 80 req strobes,
//     addrs FE00,FE01,FE04,...,FE9D.
//  2) ly=0, obj 5 Y=16 X=8, 8x8 -> count=1, slot0={8'd8,6'd5,4'd0}; ly=7 -> row 7; ly=8 -> no hit.
//  3) Tall mode, obj 3 Y=10, ly=9 -> hit row 15; 8x8 same ly -> no hit; ly=10 -> no hit.
//  4) 12 objs (idx 0..11) all hitting ly=20 -> count=10, slots = idx 0..9, idx 10,11 dropped.
//  5) oam_valid_in=0 whole scan -> Y=X=FF everywhere, ly=0 -> count=0; ly=239 never occurs,
//     check no hit for ly<=153.
//  6) Assert reset at idx 20 after 2 hits -> slots/count 0, busy 0, no done;
//     restart -> normal result; start_in pulsed while busy -> ignored, single done.

Source files
------------

// File: rtl/oam_scanner.sv
// OAM scanner: walks every OAM entry during mode 2 (two T-cycles per entry),
// picks the first MAX_SLOTS sprites that overlap the latched line, and builds
// the sprite buffer read by the mode-3 sprite fetcher.
module oam_scanner #(
  parameter int          NUM_OBJS  = 40,
  parameter int          MAX_SLOTS = 10,
  parameter logic [15:0] OAM_BASE  = 16'hFE00
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        tclk_in,
  input  logic                        start_in,
  input  logic [7:0]                  ly_in,
  input  logic                        tall_sprite_mode_in,
  output logic [15:0]                 oam_addr_out,
  output logic                        oam_req_out,
  input  logic [7:0]                  oam_data_in,
  input  logic                        oam_valid_in,
  output logic [MAX_SLOTS-1:0][17:0]  sprite_buffer_out,
  output logic [3:0]                  sprite_count_out,
  output logic                        busy_out,
  output logic                        done_out
);

  typedef enum logic [1:0] {
    IDLE,
    READ_Y,
    READ_X,
    DRAIN
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_OBJS - 1);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_SLOTS);

  state_t                      state_q, state_d;
  logic [5:0]                  idx_q, idx_d;
  logic                        pend_q, pend_d;
  logic [7:0]                  y_hold_q, y_hold_d;
  logic [7:0]                  ly_q, ly_d;
  logic                        tall_q, tall_d;
  logic [MAX_SLOTS-1:0][17:0]  slots_q, slots_d;
  logic [3:0]                  count_q, count_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [7:0]  rd_data;
  logic [5:0]  commit_num;
  logic [8:0]  line_off;
  logic [8:0]  diff;
  logic [4:0]  height;
  logic        hit;
  logic        do_commit;

  // Missing OAM data reads as all ones, like an open bus.
  assign rd_data = oam_valid_in ? oam_data_in : 8'hFF;

  // Overlap test of the held Y against the latched line; the sprite being
  // committed is the previous entry while scanning and the last one in DRAIN.
  always_comb begin
    commit_num = (state_q == DRAIN) ? idx_q : (idx_q - 6'd1);
    line_off   = {1'b0, ly_q} + 9'd16;
    diff       = line_off - {1'b0, y_hold_q};
    height     = tall_q ? 5'd16 : 5'd8;
    hit        = (line_off >= {1'b0, y_hold_q}) && (diff < {4'b0, height});
  end

  // Scan sequencing, OAM requests, and sprite buffer insertion.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    y_hold_d     = y_hold_q;
    ly_d         = ly_q;
    tall_d       = tall_q;
    slots_d      = slots_q;
    count_d      = count_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    do_commit    = 1'b0;
    oam_addr_out = 16'h0;
    oam_req_out  = 1'b0;

    case (state_q)
      IDLE: begin
        if (tclk_in && start_in) begin
          ly_d    = ly_in;
          tall_d  = tall_sprite_mode_in;
          slots_d = '0;
          count_d = 4'd0;
          idx_d   = 6'd0;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = READ_Y;
        end
      end
      READ_Y: begin
        oam_addr_out = OAM_BASE + {8'h0, idx_q, 2'b00};
        oam_req_out  = tclk_in;
        if (tclk_in) begin
          do_commit = pend_q;
          state_d   = READ_X;
        end
      end
      READ_X: begin
        oam_addr_out = OAM_BASE + {8'h0, idx_q, 2'b00} + 16'd1;
        oam_req_out  = tclk_in;
        if (tclk_in) begin
          y_hold_d = rd_data;
          pend_d   = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = READ_Y;
          end
        end
      end
      DRAIN: begin
        if (tclk_in) begin
          do_commit = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_commit && hit && (count_q < MAX_CNT)) begin
      for (int i = 0; i < MAX_SLOTS; i++) begin
        if (count_q == 4'(i)) begin
          slots_d[i] = {rd_data, commit_num, diff[3:0]};
        end
      end
      count_d = count_q + 4'd1;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      idx_q    <= 6'd0;
      pend_q   <= 1'b0;
      y_hold_q <= 8'h0;
      ly_q     <= 8'h0;
      tall_q   <= 1'b0;
      slots_q  <= '0;
      count_q  <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      y_hold_q <= y_hold_d;
      ly_q     <= ly_d;
      tall_q   <= tall_d;
      slots_q  <= slots_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sprite_buffer_out = slots_q;
  assign sprite_count_out  = count_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;

endmodule
